sdp_burst_rd: RTL and testbench

- Read-side initiator for the sdp simple dual-port RAM. Accepts a burst command {length, base address}, issues sequential addresses on the RAM read-address dti, and collects the returned words.
- Emits the words as an eot-terminated output stream.
- Sits between stream consumers and the sdp rd_addr/rd_data ports. A 2-entry output skid buffer decouples RAM timing from downstream backpressure.

---
 rtl/sdp_burst_rd.sv | 172 +++++++++++++++++
 tb/tb_sdp_burst_rd.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_burst_rd.sv
// Burst read initiator for the sdp RAM: turns {len, base} commands into sequential
// read addresses and streams the returned words out with eot on the last one.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; len==0 commands are simply consumed
// ST_ISSUE | presenting addr_reg on rd_addr until len addresses have gone
// ST_DRAIN | all addresses issued; waiting for the eot word to leave dout
module sdp_burst_rd #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [W_LEN+W_ADDR-1:0] i_cmd_data,
  output logic                    o_rd_addr_valid,
  input  logic                    i_rd_addr_ready,
  output logic [W_ADDR-1:0]       o_rd_addr_data,
  input  logic                    i_rd_data_valid,
  output logic                    o_rd_data_ready,
  input  logic [W_DATA-1:0]       i_rd_data_data,
  output logic                    o_dout_valid,
  input  logic                    i_dout_ready,
  output logic [W_DATA:0]         o_dout_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [W_LEN-1:0]  LEN_ONE  = 1;
  localparam logic [W_ADDR-1:0] ADDR_ONE = 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W_ADDR-1:0] r_addr;
  logic [W_LEN-1:0]  r_len;
  logic [W_LEN-1:0]  r_iss_cnt;
  logic [W_LEN-1:0]  r_ret_cnt;
  logic [W_DATA:0]   r_skid0;
  logic [W_DATA:0]   r_skid1;
  logic [1:0]        r_skid_cnt;

  logic [W_LEN-1:0]  w_cmd_len;
  logic [W_ADDR-1:0] w_cmd_base;
  logic [W_LEN-1:0]  w_len_m1;
  logic              w_cmd_hs;
  logic              w_addr_hs;
  logic              w_push;
  logic              w_pop;
  logic              w_last_iss;
  logic              w_pop_eot;
  logic [W_DATA:0]   w_push_word;

  assign w_cmd_len   = i_cmd_data[W_LEN+W_ADDR-1:W_ADDR];
  assign w_cmd_base  = i_cmd_data[W_ADDR-1:0];
  assign w_len_m1    = r_len - LEN_ONE;
  assign w_cmd_hs    = i_cmd_valid & o_cmd_ready;
  assign w_addr_hs   = o_rd_addr_valid & i_rd_addr_ready;
  assign w_push      = i_rd_data_valid & o_rd_data_ready;
  assign w_pop       = o_dout_valid & i_dout_ready;
  assign w_last_iss  = w_addr_hs & (r_iss_cnt == w_len_m1);
  assign w_pop_eot   = w_pop & o_dout_data[W_DATA];
  assign w_push_word = {(r_ret_cnt == w_len_m1), i_rd_data_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs depend only on the registered state, never on ready.
  always_comb begin
    w_state_nxt     = r_state;
    o_cmd_ready     = 1'b0;
    o_rd_addr_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = 1'b1;
        if (w_cmd_hs && (w_cmd_len != '0)) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_rd_addr_valid = 1'b1;
        if (w_last_iss) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop_eot) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_rd_addr_data = r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_addr    <= w_cmd_base;
        r_len     <= w_cmd_len;
        r_iss_cnt <= '0;
        r_ret_cnt <= '0;
      end else begin
        if (w_addr_hs) begin
          r_addr    <= r_addr + ADDR_ONE;
          r_iss_cnt <= r_iss_cnt + LEN_ONE;
        end
        if (w_push) begin
          r_ret_cnt <= r_ret_cnt + LEN_ONE;
        end
      end
    end
  end

  // Two-entry skid: r_skid0 is always the head presented on dout.
  assign o_rd_data_ready = (r_skid_cnt != 2'd2);
  assign o_dout_valid    = (r_skid_cnt != 2'd0);
  assign o_dout_data     = r_skid0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_skid_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_skid_cnt == 2'd0) begin
            r_skid0 <= w_push_word;
          end else begin
            r_skid1 <= w_push_word;
          end
          r_skid_cnt <= r_skid_cnt + 2'd1;
        end
        2'b01: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 2'd1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= w_push_word;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= w_push_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdp_burst_rd.sv
// Directed bench for sdp_burst_rd with a registered in-order RAM read port model
// (mem[a] = 3*a) and a monitor that logs every handshake.
module tb_sdp_burst_rd;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [31:0] i_cmd_data;
  logic        o_rd_addr_valid;
  logic        i_rd_addr_ready;
  logic [15:0] o_rd_addr_data;
  logic        i_rd_data_valid;
  logic        o_rd_data_ready;
  logic [15:0] i_rd_data_data;
  logic        o_dout_valid;
  logic        i_dout_ready;
  logic [16:0] o_dout_data;

  sdp_burst_rd dut (
    .clk             (clk),
    .rst             (rst),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_data      (i_cmd_data),
    .o_rd_addr_valid (o_rd_addr_valid),
    .i_rd_addr_ready (i_rd_addr_ready),
    .o_rd_addr_data  (o_rd_addr_data),
    .i_rd_data_valid (i_rd_data_valid),
    .o_rd_data_ready (o_rd_data_ready),
    .i_rd_data_data  (i_rd_data_data),
    .o_dout_valid    (o_dout_valid),
    .i_dout_ready    (i_dout_ready),
    .o_dout_data     (o_dout_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [15:0] a);
    return 16'(a * 16'd3);
  endfunction

  // RAM read port: one registered output slot, held while rd_data is stalled.
  logic r_dv;
  logic [15:0] r_dq;
  assign i_rd_addr_ready = !r_dv || o_rd_data_ready;
  assign i_rd_data_valid = r_dv;
  assign i_rd_data_data  = r_dq;

  always @(posedge clk) begin
    if (rst) begin
      r_dv <= 1'b0;
      r_dq <= 16'h0;
    end else if (o_rd_addr_valid && i_rd_addr_ready) begin
      r_dv <= 1'b1;
      r_dq <= mem(o_rd_addr_data);
    end else if (o_rd_data_ready) begin
      r_dv <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] q_dat[$];
  logic        q_eot[$];
  logic [15:0] q_addr[$];
  int          q_out_cyc[$];
  int          q_cmd_cyc[$];
  int          mcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mcnt = 0;
    end else begin
      chk("rd_data_ready_vs_fill", {31'd0, o_rd_data_ready}, {31'd0, (mcnt < 2)});
      chk("dout_valid_vs_fill", {31'd0, o_dout_valid}, {31'd0, (mcnt != 0)});
      if (i_rd_data_valid) chk("rd_data_in_idle", {31'd0, o_cmd_ready}, 32'd0);
      if (i_cmd_valid && o_cmd_ready) q_cmd_cyc.push_back(cyc);
      if (o_rd_addr_valid && i_rd_addr_ready) q_addr.push_back(o_rd_addr_data);
      if (o_dout_valid && i_dout_ready) begin
        q_dat.push_back(o_dout_data[15:0]);
        q_eot.push_back(o_dout_data[16]);
        q_out_cyc.push_back(cyc);
      end
      mcnt = mcnt + ((i_rd_data_valid && o_rd_data_ready) ? 1 : 0)
                  - ((o_dout_valid && i_dout_ready) ? 1 : 0);
    end
  end

  logic bp_on = 1'b0;
  logic dout_hold = 1'b0;
  int   bp_cnt = 0;

  initial begin
    i_dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (dout_hold) i_dout_ready = 1'b0;
      else if (!bp_on) i_dout_ready = 1'b1;
      else if (q_dat.size() == 0) i_dout_ready = 1'b1;
      else if (bp_cnt < 10) begin
        i_dout_ready = 1'b0;
        bp_cnt++;
      end else i_dout_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic [15:0]  base;
    logic [15:0]  len;
    logic         bp;
    logic         chk_lat;
    logic [127:0] exp_dat;
    logic [7:0]   exp_eot;
  } vec_t;

  vec_t vecs[3];
  vec_t vpost;

  logic [15:0] b_dat[5]  = '{16'h0000, 16'h0003, 16'h0030, 16'h0033, 16'h0036};
  logic [15:0] b_addr[5] = '{16'h0000, 16'h0001, 16'h0010, 16'h0011, 16'h0012};
  logic        b_eot[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic clear_logs();
    q_dat.delete();
    q_eot.delete();
    q_addr.delete();
    q_out_cyc.delete();
    q_cmd_cyc.delete();
  endtask

  task automatic wait_hs(input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (o_cmd_ready) got = 1'b1;
    end
    chk({tag, "_cmd_hs_timeout"}, {31'd0, got}, 32'd1);
  endtask

  task automatic send_cmd(input logic [31:0] d, input string tag);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_data  = d;
    wait_hs(tag);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      if (q_dat.size() >= n && o_cmd_ready) done = 1'b1;
    end
    chk({tag, "_done_timeout"}, {31'd0, done}, 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    n = int'(v.len);
    clear_logs();
    bp_cnt = 0;
    bp_on  = v.bp;
    send_cmd({v.len, v.base}, tag);
    wait_done(n, tag);
    bp_on = 1'b0;
    chk({tag, "_n_dout"}, q_dat.size(), n);
    chk({tag, "_n_addr"}, q_addr.size(), n);
    for (int i = 0; i < n && i < q_dat.size() && i < q_addr.size(); i++) begin
      chk($sformatf("%s_dat%0d", tag, i), {16'd0, q_dat[i]}, {16'd0, v.exp_dat[i*16 +: 16]});
      chk($sformatf("%s_eot%0d", tag, i), {31'd0, q_eot[i]}, {31'd0, v.exp_eot[i]});
      chk($sformatf("%s_addr%0d", tag, i), {16'd0, q_addr[i]}, {16'd0, 16'(v.base + 16'(i))});
      if (v.chk_lat)
        chk($sformatf("%s_cyc%0d", tag, i), q_out_cyc[i] - q_cmd_cyc[0], 3 + i);
    end
  endtask

  initial begin
    vecs[0] = '{16'h0010, 16'd4, 1'b0, 1'b1,
                {64'h0, 16'h0039, 16'h0036, 16'h0033, 16'h0030}, 8'b0000_1000};
    vecs[1] = '{16'hFFFE, 16'd3, 1'b0, 1'b0,
                {80'h0, 16'h0000, 16'hFFFD, 16'hFFFA}, 8'b0000_0100};
    vecs[2] = '{16'h0000, 16'd8, 1'b1, 1'b0,
                {16'h0015, 16'h0012, 16'h000F, 16'h000C,
                 16'h0009, 16'h0006, 16'h0003, 16'h0000}, 8'b1000_0000};
    vpost   = '{16'h0040, 16'd2, 1'b0, 1'b0,
                {96'h0, 16'h00C3, 16'h00C0}, 8'b0000_0010};

    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_data  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rst_rd_addr_valid", {31'd0, o_rd_addr_valid}, 32'd0);
    chk("rst_dout_valid", {31'd0, o_dout_valid}, 32'd0);
    chk("rst_rd_data_ready", {31'd0, o_rd_data_ready}, 32'd1);

    for (int t = 0; t < 3; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

    // len=0 immediately followed by a one-word command
    clear_logs();
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_data  = {16'd0, 16'h0000};
    wait_hs("len0");
    @(posedge clk);
    #1;
    i_cmd_data = {16'd1, 16'h0020};
    wait_hs("len1");
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    wait_done(1, "len0");
    chk("len0_n_cmd", q_cmd_cyc.size(), 2);
    if (q_cmd_cyc.size() == 2) chk("len0_next_cycle", q_cmd_cyc[1] - q_cmd_cyc[0], 1);
    chk("len0_n_addr", q_addr.size(), 1);
    chk("len0_n_dout", q_dat.size(), 1);
    if (q_addr.size() > 0) chk("len0_addr", {16'd0, q_addr[0]}, 32'h20);
    if (q_dat.size() > 0) begin
      chk("len0_dat", {16'd0, q_dat[0]}, 32'h60);
      chk("len0_eot", {31'd0, q_eot[0]}, 32'd1);
    end

    // back-to-back commands with cmd.valid held
    clear_logs();
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_data  = {16'd2, 16'h0000};
    wait_hs("b2b_a");
    @(posedge clk);
    #1;
    i_cmd_data = {16'd3, 16'h0010};
    wait_hs("b2b_b");
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    wait_done(5, "b2b");
    chk("b2b_n_dout", q_dat.size(), 5);
    chk("b2b_n_addr", q_addr.size(), 5);
    if (q_cmd_cyc.size() == 2 && q_out_cyc.size() >= 2)
      chk("b2b_cmd_after_eot", q_cmd_cyc[1] - q_out_cyc[1], 1);
    for (int i = 0; i < 5 && i < q_dat.size() && i < q_addr.size(); i++) begin
      chk($sformatf("b2b_dat%0d", i), {16'd0, q_dat[i]}, {16'd0, b_dat[i]});
      chk($sformatf("b2b_eot%0d", i), {31'd0, q_eot[i]}, {31'd0, b_eot[i]});
      chk($sformatf("b2b_addr%0d", i), {16'd0, q_addr[i]}, {16'd0, b_addr[i]});
    end

    // reset after two of six words
    begin
      logic got2;
      clear_logs();
      send_cmd({16'd6, 16'h0000}, "rstmid");
      got2 = 1'b0;
      for (int k = 0; k < 100 && !got2; k++) begin
        @(posedge clk);
        if (q_dat.size() >= 2) got2 = 1'b1;
      end
      chk("rstmid_two_words_timeout", {31'd0, got2}, 32'd1);
      dout_hold = 1'b1;
      #1;
      rst = 1'b1;
      @(posedge clk);
      dout_hold = 1'b0;
      #1;
      rst = 1'b0;
      chk("rstmid_dout_valid", {31'd0, o_dout_valid}, 32'd0);
      chk("rstmid_rd_addr_valid", {31'd0, o_rd_addr_valid}, 32'd0);
      chk("rstmid_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
      chk("rstmid_words_before_rst", q_dat.size(), 2);
    end
    run_vec(vpost, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
